// File: rtl/bidir_mod_counter_if.sv
// Control and status bundle for the bidirectional modulo counter.
// Master drives controls; slave returns count, wrap pulse and bound flag.
interface bidir_mod_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             dir;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] limit;
  logic             sat_mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             wrap;
  logic             at_bound;

  modport master (
    output en, dir, step, limit,
    output sat_mode, load, load_val,
    input  count, wrap, at_bound
  );

  modport slave (
    input  en, dir, step, limit,
    input  sat_mode, load, load_val,
    output count, wrap, at_bound
  );
endinterface

// File: rtl/bidir_mod_counter.sv
// Up/down counter with runtime limit, step, load, wrap/saturate modes.
// Optional PRESCALE_EN macro divides enabled cycles by PRESCALE.
module bidir_mod_counter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic               clk,
  input  logic               reset,
  bidir_mod_counter_if.slave bus
);
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic [WIDTH-1:0] s_eff;
  logic [WIDTH-1:0] ld_clamp;
  logic [WIDTH-1:0] nxt;
  logic             nxt_wrap;
  logic             tick;
  logic             oob;
  logic [WIDTH:0]   c;
  logic [WIDTH:0]   l;
  logic [WIDTH:0]   s;
  logic [WIDTH:0]   up;

  assign s_eff = (bus.step <= bus.limit)
               ? bus.step : bus.limit;
  assign ld_clamp = (bus.load_val <= bus.limit)
                  ? bus.load_val : bus.limit;

  assign c   = {1'b0, count_q};
  assign l   = {1'b0, bus.limit};
  assign s   = {1'b0, s_eff};
  assign up  = c + s;
  assign oob = count_q > bus.limit;

  always_comb begin
    nxt      = count_q;
    nxt_wrap = 1'b0;
    if (bus.step != '0) begin
      if (oob) begin
        nxt = (bus.sat_mode || !bus.dir)
            ? bus.limit : '0;
        nxt_wrap = 1'b1;
      end else if (bus.limit == '0) begin
        // modulo-1 range: any nonzero step is a wrap
        nxt      = '0;
        nxt_wrap = !bus.sat_mode;
      end else if (bus.dir) begin
        if (up <= l) begin
          nxt = up[WIDTH-1:0];
        end else if (!bus.sat_mode) begin
          nxt      = WIDTH'(up - l - ONE);
          nxt_wrap = 1'b1;
        end else begin
          nxt      = bus.limit;
          nxt_wrap = count_q != bus.limit;
        end
      end else begin
        if (c >= s) begin
          nxt = WIDTH'(c - s);
        end else if (!bus.sat_mode) begin
          nxt      = WIDTH'(c + l + ONE - s);
          nxt_wrap = 1'b1;
        end else begin
          nxt      = '0;
          nxt_wrap = count_q != '0;
        end
      end
    end
  end

`ifdef PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0] pre_q;

  assign tick = pre_q == PW'(PRESCALE - 1);

  always_ff @(posedge clk) begin
    if (reset || bus.load) begin
      pre_q <= '0;
    end else if (bus.en) begin
      pre_q <= tick ? '0 : pre_q + PW'(1);
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else if (bus.load) begin
      count_q <= ld_clamp;
      wrap_q  <= 1'b0;
    end else if (bus.en && tick) begin
      count_q <= nxt;
      wrap_q  <= nxt_wrap;
    end else begin
      wrap_q  <= 1'b0;
    end
  end

  assign bus.count    = count_q;
  assign bus.wrap     = wrap_q;
  assign bus.at_bound = bus.dir
                      ? (count_q == bus.limit)
                      : (count_q == '0);
endmodule

// File: tb/tb_bidir_mod_counter.sv
// Randomised and directed bench for bidir_mod_counter (WIDTH=8).
// Reference model uses plain integer modulo/min/max arithmetic.
module tb_bidir_mod_counter;
  localparam int W  = 8;
  localparam int PS = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  int m_cnt = 0;
  bit m_wrap = 1'b0;
`ifdef PRESCALE_EN
  int m_pre = 0;
`endif

  bidir_mod_counter_if #(.WIDTH(W)) bus ();

  bidir_mod_counter #(
    .WIDTH(W),
    .PRESCALE(PS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Advance one clock, updating the model from inputs seen at the edge.
  task automatic tick();
    int lim, c, s, nc;
    bit nw, adv;
    lim = int'(bus.limit);
    c   = m_cnt;
    s   = (bus.step <= bus.limit) ? int'(bus.step) : lim;
    nc  = c;
    nw  = 1'b0;
    if (reset) begin
      nc = 0;
`ifdef PRESCALE_EN
      m_pre = 0;
`endif
    end else if (bus.load) begin
      nc = (int'(bus.load_val) < lim) ? int'(bus.load_val) : lim;
`ifdef PRESCALE_EN
      m_pre = 0;
`endif
    end else if (bus.en) begin
      adv = 1'b1;
`ifdef PRESCALE_EN
      adv   = (m_pre == PS - 1);
      m_pre = adv ? 0 : m_pre + 1;
`endif
      if (adv && bus.step != 0) begin
        if (c > lim) begin
          nc = (bus.sat_mode || !bus.dir) ? lim : 0;
          nw = 1'b1;
        end else if (!bus.sat_mode) begin
          if (bus.dir) nc = (c + s) % (lim + 1);
          else nc = (((c - s) % (lim + 1)) + lim + 1) % (lim + 1);
          nw = bus.dir ? (c + s > lim) : (c < s);
          if (lim == 0) nw = 1'b1;
        end else if (bus.dir) begin
          nc = (c + s > lim) ? lim : c + s;
          nw = (c + s > lim) && (c != lim);
        end else begin
          nc = (c < s) ? 0 : c - s;
          nw = (c < s) && (c != 0);
        end
      end
    end
    @(posedge clk);
    #1;
    m_cnt  = nc;
    m_wrap = nw;
  endtask

  task automatic set_ctl(input bit e, input bit d, input int st,
                         input int lm, input bit sm);
    bus.en       = e;
    bus.dir      = d;
    bus.step     = W'(st);
    bus.limit    = W'(lm);
    bus.sat_mode = sm;
    bus.load     = 1'b0;
  endtask

  task automatic do_load(input int v);
    bus.load     = 1'b1;
    bus.load_val = W'(v);
    tick();
    bus.load     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_ctl(1'b1, 1'b1, 1, 255, 1'b0);
    bus.load_val = '0;
    tick();
    tick();
    checks++;
    if (bus.count !== 8'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", bus.count);
    end
    checks++;
    if (bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_wrap: got %0b want 0", bus.wrap);
    end
    reset = 1'b0;
    m_cnt = 0;
  endtask

  task automatic test_full_scale();
    reset = 1'b1;
    set_ctl(1'b1, 1'b1, 1, 255, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 260; i++) begin
      tick();
      checks++;
      if (bus.count !== W'(i % 256) || bus.wrap !== (i == 256)) begin
        errors++;
        $display("FAIL full_scale cyc %0d: count=%0d wrap=%0b want %0d/%0b",
                 i, bus.count, bus.wrap, i % 256, i == 256);
      end
    end
    checks++;
    if (bus.count !== 8'd4) begin
      errors++;
      $display("FAIL full_scale_end: got %0d want 4", bus.count);
    end
  endtask

  task automatic test_wrap_down();
    int exp_c[6] = '{4, 1, 8, 5, 2, 9};
    bit exp_w[6] = '{0, 0, 1, 0, 0, 1};
    set_ctl(1'b1, 1'b0, 3, 9, 1'b0);
    do_load(4);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      checks++;
      if (bus.count !== W'(exp_c[i]) || bus.wrap !== exp_w[i]) begin
        errors++;
        $display("FAIL wrap_down step %0d: count=%0d wrap=%0b want %0d/%0b",
                 i, bus.count, bus.wrap, exp_c[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_saturate();
    int exp_c[4] = '{100, 100, 0, 0};
    bit exp_w[4] = '{1, 0, 1, 0};
    set_ctl(1'b0, 1'b1, 7, 100, 1'b1);
    do_load(95);
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        bus.en  = 1'b0;
        bus.dir = 1'b0;
        do_load(3);
        bus.en  = 1'b1;
      end
      tick();
      checks++;
      if (bus.count !== W'(exp_c[i]) || bus.wrap !== exp_w[i]) begin
        errors++;
        $display("FAIL saturate step %0d: count=%0d wrap=%0b want %0d/%0b",
                 i, bus.count, bus.wrap, exp_c[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_limit_lowered();
    int exp_c[2] = '{0, 50};
    for (int m = 0; m < 2; m++) begin
      set_ctl(1'b0, 1'b1, 1, 255, m[0]);
      do_load(200);
      bus.limit = 8'd50;
      bus.en    = 1'b1;
      tick();
      checks++;
      if (bus.count !== W'(exp_c[m]) || bus.wrap !== 1'b1) begin
        errors++;
        $display("FAIL limit_lowered sat=%0d: count=%0d wrap=%0b want %0d/1",
                 m, bus.count, bus.wrap, exp_c[m]);
      end
    end
  endtask

  task automatic test_load_priority();
    set_ctl(1'b1, 1'b1, 1, 150, 1'b0);
    do_load(200);
    checks++;
    if (bus.count !== 8'd150 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL load_clamp: count=%0d wrap=%0b want 150/0",
               bus.count, bus.wrap);
    end
    reset = 1'b1;
    do_load(77);
    reset = 1'b0;
    checks++;
    if (bus.count !== 8'd0) begin
      errors++;
      $display("FAIL reset_over_load: count=%0d want 0", bus.count);
    end
  endtask

`ifdef PRESCALE_EN
  task automatic test_prescale();
    int enabled;
    reset = 1'b1;
    set_ctl(1'b1, 1'b1, 1, 255, 1'b0);
    tick();
    reset   = 1'b0;
    enabled = 0;
    for (int i = 1; i <= 14; i++) begin
      bus.en = !(i == 6 || i == 7);
      if (bus.en) enabled++;
      tick();
      checks++;
      if (bus.count !== W'(enabled / PS) || bus.wrap !== 1'b0) begin
        errors++;
        $display("FAIL prescale cyc %0d: count=%0d wrap=%0b want %0d/0",
                 i, bus.count, bus.wrap, enabled / PS);
      end
    end
  endtask
`endif

  task automatic test_random();
    int lim;
    bit ab;
    lim = 20;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0)
        lim = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 20);
      reset        = ($urandom_range(0, 59) == 0);
      bus.load     = ($urandom_range(0, 15) == 0);
      bus.load_val = W'($urandom_range(0, 255));
      bus.en       = ($urandom_range(0, 3) != 0);
      bus.dir      = $urandom_range(0, 1) == 1;
      bus.sat_mode = $urandom_range(0, 1) == 1;
      bus.limit    = W'(lim);
      bus.step     = W'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 255)
                                                    : $urandom_range(0, 5));
      tick();
      ab = bus.dir ? (m_cnt == lim) : (m_cnt == 0);
      checks++;
      if (bus.count !== W'(m_cnt) || bus.wrap !== m_wrap
          || bus.at_bound !== ab) begin
        errors++;
        $display("FAIL random cyc %0d: count=%0d wrap=%0b at_bound=%0b want %0d/%0b/%0b",
                 i, bus.count, bus.wrap, bus.at_bound, m_cnt, m_wrap, ab);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
`ifdef PRESCALE_EN
    test_prescale();
`else
    test_full_scale();
    test_wrap_down();
    test_saturate();
    test_limit_lowered();
    test_load_priority();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bidir_mod_counter.md
Name: bidir_mod_counter

Overview:
Parametrised up/down counter for the user project area. It generalises the fixed 8-bit bidirectional counter with these additions:
- configurable width
- runtime modulo limit
- variable step
- synchronous load
- wrap or saturate mode
- wrap-event pulse output

Count drives io_out pads; control comes from io_in pads or LA probes. Single clock domain (wb_clk_i).

Parameters:
WIDTH, 8, counter/limit/step/load width in bits (2..32).
PRESCALE, 4, enabled-cycle divisor; only used when PRESCALE_EN is defined (2..256).

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
en  input  1  advance enable; count changes only on cycles with en=1 (and prescaler tick, if compiled in).
dir  input  1  1 = count up, 0 = count down; sampled every cycle.
step  input  WIDTH  increment/decrement magnitude.
limit  input  WIDTH  inclusive maximum; count range is 0..limit.
sat_mode  input  1  0 = wrap modulo (limit+1), 1 = saturate at 0/limit.
load  input  1  synchronous load strobe.
load_val  input  WIDTH  value loaded when load=1.
count  output  WIDTH  registered count.
wrap  output  1  registered one-cycle pulse, set in the same cycle count takes a wrapped or saturated value.
at_bound  output  1  combinational: (count==limit) when dir=1, (count==0) when dir=0.

Behaviour:
- Priority each rising edge: reset > load > advance > hold.
- Reset: count=0, wrap=0, prescaler=0. Reset mid-load or mid-advance discards both.
- Load: count <= min(load_val, limit); wrap <= 0; prescaler cleared. A load with en=1 loads only; no advance that cycle.
- Advance occurs when en=1 and load=0 (and prescaler tick).
- Effective step s:
  - s = step if step <= limit, else s = limit.
  - s=0 holds count, with wrap=0.
- Arithmetic uses WIDTH+1 bits internally; no intermediate overflow.
- Out-of-range: if count > limit at an advance (limit lowered at runtime), count <= limit in sat_mode, else 0 (up) / limit (down). wrap <= 1.
- Up (dir=1), in range:
  - count+s <= limit: count <= count+s, wrap <= 0.
  - otherwise, wrap mode: count <= count+s-limit-1, wrap <= 1.
  - otherwise, sat mode: count <= limit, wrap <= 1 only if count != limit before the edge.
- Down (dir=0), in range:
  - count >= s: count <= count-s, wrap <= 0.
  - otherwise, wrap mode: count <= count+limit+1-s, wrap <= 1.
  - otherwise, sat mode: count <= 0, wrap <= 1 only if count != 0 before the edge.
- Full-scale example: limit = 2^WIDTH-1, step=1 reproduces plain modulo-2^WIDTH up/down counting (255->0 up, 0->255 down for WIDTH=8).
- limit=0: count pinned at 0.
  - wrap mode: every advance with step != 0 pulses wrap.
  - sat mode: wrap never pulses.
- Hold cycles (en=0, or no prescaler tick): count unchanged, wrap <= 0.
- Direction, limit and sat_mode changes take effect on the next edge; no pipelining, latency 1 cycle from inputs to count.

Optional Feature:
Macro PRESCALE_EN.
- Defined: internal counter of ceil(log2(PRESCALE)) bits increments on each en=1 cycle (load=0). Advance happens only on the cycle it equals PRESCALE-1, and it then returns to 0.
  - en=0 freezes the prescaler.
  - reset and load clear the prescaler.
  - wrap is asserted only on advancing edges.
- Undefined: every en=1, load=0 cycle advances; PRESCALE is ignored; no prescaler flops synthesised.

Test Plan:
All tests use WIDTH=8.
1. Reset, then limit=255, step=1, dir=1, en=1 for 260 cycles -> count 0..255, wraps to 0 at cycle 256 with wrap=1 for that cycle only; ends at 4.
2. limit=9, step=3, dir=0, wrap mode, load_val=4 loaded -> sequence 4,1,8,5,2,9; wrap=1 on the 1->8 and 2->9 updates.
3. sat_mode=1, limit=100, step=7, dir=1, load 95 -> 100 (wrap=1), 100 (wrap=0). dir=0 from 3 -> 0 (wrap=1), 0 (wrap=0).
4. count=200, limit changed to 50, advance dir=1 wrap mode -> count=0, wrap=1. Repeat with sat_mode=1 -> count=50, wrap=1.
5. load=1 and en=1 together with load_val=300-equivalent clamp (load_val=200, limit=150) -> count=150, no advance. reset asserted the same cycle as load -> count=0.
6. PRESCALE_EN defined, PRESCALE=4, step=1, en=1 for 12 cycles -> count 0->3, changing on cycles 4, 8, 12. en toggled off for 2 cycles mid-run -> changes delayed by exactly 2 cycles.
